// File: rtl/efuse_read_seq_if.sv
// Controller-side read handshake between the eFuse read/write controller and the
// macro read sequencer.
interface efuse_read_seq_if #(
  parameter int unsigned NR = 64
) ();
  // A 256-bit read has a single word, but the select still needs one bit of width.
  localparam int unsigned SelW = (NR >= 256) ? 1 : $clog2(256 / NR);

  logic            read_start;
  logic [SelW-1:0] efuse_read_sel;
  logic            efuse_busy_write;
  logic            read_done;
  logic [NR-1:0]   read_data;
  logic            efuse_busy_read;

  modport master (
    output read_start,
    output efuse_read_sel,
    output efuse_busy_write,
    input  read_done,
    input  read_data,
    input  efuse_busy_read
  );

  modport slave (
    input  read_start,
    input  efuse_read_sel,
    input  efuse_busy_write,
    output read_done,
    output read_data,
    output efuse_busy_read
  );
endinterface

// File: rtl/efuse_read_seq.sv
// Macro-side read sequencer for the 32 x 8-bit eFuse array: expands one NR-bit read
// into NR/8 timed byte accesses and assembles the returned word.
module efuse_read_seq #(
  parameter int unsigned NR       = 64,
  parameter int unsigned T_SETUP  = 2,
  parameter int unsigned T_STROBE = 4,
  parameter int unsigned T_HOLD   = 2
) (
  input  logic              clk,
  input  logic              rst,
  efuse_read_seq_if.slave   rd,
  output logic              efuse_csb,
  output logic              efuse_load,
  output logic              efuse_pgenb,
  output logic              efuse_strobe,
  output logic [4:0]        efuse_a,
  input  logic [7:0]        efuse_q
);

  localparam int unsigned NB    = NR / 8;
  localparam int unsigned SelW  = (NR >= 256) ? 1 : $clog2(256 / NR);
  localparam int unsigned ByteW = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned TMax0 = (T_SETUP > T_STROBE) ? T_SETUP : T_STROBE;
  localparam int unsigned TMax  = (TMax0 > T_HOLD) ? TMax0 : T_HOLD;
  localparam int unsigned TW    = (TMax > 1) ? $clog2(TMax) : 1;

  localparam logic [TW-1:0]    SetupLast  = TW'(T_SETUP - 1);
  localparam logic [TW-1:0]    StrobeLast = TW'(T_STROBE - 1);
  localparam logic [TW-1:0]    HoldLast   = TW'(T_HOLD - 1);
  localparam logic [ByteW-1:0] LastByte   = ByteW'(NB - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [ByteW-1:0] byte_q, byte_d;
  logic [SelW-1:0]  sel_q, sel_d;
  logic [NR-1:0]    buf_q, buf_d;
  logic [NR-1:0]    data_q, data_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             csb_q, csb_d;
  logic             load_q, load_d;
  logic             pgenb_q, pgenb_d;
  logic             strobe_q, strobe_d;
  logic [4:0]       a_q, a_d;

  // Word index times bytes-per-word lands inside the 32-byte array by construction.
  function automatic logic [4:0] byte_addr(input logic [SelW-1:0] sel,
                                           input logic [ByteW-1:0] idx);
    return 5'((32'(sel) * NB) + 32'(idx));
  endfunction

  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    byte_d   = byte_q;
    sel_d    = sel_q;
    buf_d    = buf_q;
    data_d   = data_q;
    done_d   = 1'b0;
    csb_d    = csb_q;
    load_d   = load_q;
    pgenb_d  = 1'b1;
    strobe_d = strobe_q;
    a_d      = a_q;

    unique case (state_q)
      StIdle: begin
        if (rd.read_start && !rd.efuse_busy_write) begin
          state_d = StSetup;
          tcnt_d  = '0;
          byte_d  = '0;
          sel_d   = rd.efuse_read_sel;
          csb_d   = 1'b0;
          load_d  = 1'b1;
          a_d     = byte_addr(rd.efuse_read_sel, '0);
        end
      end
      StSetup: begin
        if (tcnt_q == SetupLast) begin
          state_d  = StStrobe;
          tcnt_d   = '0;
          strobe_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      StStrobe: begin
        if (tcnt_q == StrobeLast) begin
          // Macro data is only valid while strobe is still high on this edge.
          buf_d[{byte_q, 3'b000} +: 8] = efuse_q;
          state_d  = StHold;
          tcnt_d   = '0;
          strobe_d = 1'b0;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      StHold: begin
        if (tcnt_q == HoldLast) begin
          tcnt_d = '0;
          if (byte_q == LastByte) begin
            state_d = StDone;
            done_d  = 1'b1;
            data_d  = buf_q;
            csb_d   = 1'b1;
            load_d  = 1'b0;
            a_d     = '0;
          end else begin
            state_d = StSetup;
            byte_d  = byte_q + ByteW'(1);
            a_d     = byte_addr(sel_q, byte_q + ByteW'(1));
          end
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      tcnt_q   <= '0;
      byte_q   <= '0;
      sel_q    <= '0;
      buf_q    <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      csb_q    <= 1'b1;
      load_q   <= 1'b0;
      pgenb_q  <= 1'b1;
      strobe_q <= 1'b0;
      a_q      <= '0;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      byte_q   <= byte_d;
      sel_q    <= sel_d;
      buf_q    <= buf_d;
      data_q   <= data_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      csb_q    <= csb_d;
      load_q   <= load_d;
      pgenb_q  <= pgenb_d;
      strobe_q <= strobe_d;
      a_q      <= a_d;
    end
  end

  assign rd.read_done       = done_q;
  assign rd.read_data       = data_q;
  assign rd.efuse_busy_read = busy_q;
  assign efuse_csb          = csb_q;
  assign efuse_load         = load_q;
  assign efuse_pgenb        = pgenb_q;
  assign efuse_strobe       = strobe_q;
  assign efuse_a            = a_q;

endmodule

// File: tb/tb_efuse_read_seq.sv
// Scoreboard bench for efuse_read_seq: a 64-bit instance exercised by directed reads and
// a 256-bit instance checked for single-word latency and data.
module tb_efuse_read_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  efuse_read_seq_if #(.NR(64))  rd64 ();
  efuse_read_seq_if #(.NR(256)) rd256 ();

  logic       csb64, load64, pgenb64, strobe64;
  logic [4:0] a64;
  logic [7:0] q64;
  logic       csb256, load256, pgenb256, strobe256;
  logic [4:0] a256;
  logic [7:0] q256;

  // Macro model: data is a fixed function of the address, undefined outside strobe.
  assign q64  = strobe64  ? ({3'b000, a64}  ^ 8'h5A) : 8'hxx;
  assign q256 = strobe256 ? ({3'b000, a256} ^ 8'h5A) : 8'hxx;

  efuse_read_seq #(.NR(64), .T_SETUP(2), .T_STROBE(4), .T_HOLD(2)) dut64 (
    .clk          (clk),
    .rst          (rst),
    .rd           (rd64),
    .efuse_csb    (csb64),
    .efuse_load   (load64),
    .efuse_pgenb  (pgenb64),
    .efuse_strobe (strobe64),
    .efuse_a      (a64),
    .efuse_q      (q64)
  );

  efuse_read_seq #(.NR(256), .T_SETUP(2), .T_STROBE(4), .T_HOLD(2)) dut256 (
    .clk          (clk),
    .rst          (rst),
    .rd           (rd256),
    .efuse_csb    (csb256),
    .efuse_load   (load256),
    .efuse_pgenb  (pgenb256),
    .efuse_strobe (strobe256),
    .efuse_a      (a256),
    .efuse_q      (q256)
  );

  typedef struct {
    logic [63:0] data;
    int unsigned due;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_word(input int s);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'(s * 8 + k) ^ 8'h5A;
    return w;
  endfunction

  function automatic logic [255:0] exp_word256();
    logic [255:0] w;
    for (int k = 0; k < 32; k++) w[8*k +: 8] = 8'(k) ^ 8'h5A;
    return w;
  endfunction

  // {csb, load, pgenb, strobe, a, busy}; j counts cycles after the accepting edge from 0.
  function automatic logic [9:0] exp_pins(input int s, input int j);
    logic stb;
    stb = ((j % 8) >= 2) && ((j % 8) < 6);
    if (j < 64) return {1'b0, 1'b1, 1'b1, stb, 5'(s * 8 + j / 8), 1'b1};
    else if (j == 64) return {1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1};
    else return 10'b10_1000_0000;
  endfunction

  function automatic logic [9:0] pins64();
    return {csb64, load64, pgenb64, strobe64, a64, rd64.efuse_busy_read};
  endfunction

  // Monitor: every read_done of the 64-bit instance must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rd64.read_done) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done @cyc %0d: got read_done=1, expected none", cyc);
      end else begin
        e = sb_q.pop_front();
        chk("done_cycle", 256'(cyc), 256'(e.due));
        chk("read_data", 256'(rd64.read_data), 256'(e.data));
      end
    end
  end

  // Issue a one-cycle start; returns at the negedge right after the sampling edge.
  task automatic issue(input int s, input bit expect_acc, output int unsigned acc_cyc);
    @(negedge clk);
    rd64.read_start     = 1'b1;
    rd64.efuse_read_sel = 2'(s);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (expect_acc) sb_q.push_back('{exp_word(s), cyc + 64});
    @(negedge clk);
    rd64.read_start = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    int unsigned t_done;
    logic [4:0]  last_a;
    bit          seen;

    rd64.read_start        = 1'b0;
    rd64.efuse_read_sel    = '0;
    rd64.efuse_busy_write  = 1'b0;
    rd256.read_start       = 1'b0;
    rd256.efuse_read_sel   = '0;
    rd256.efuse_busy_write = 1'b0;

    // Reset held for three cycles: idle pins, no strobe.
    repeat (3) begin
      @(negedge clk);
      chk("reset_pins64", 256'(pins64()), 256'(10'b10_1000_0000));
      chk("reset_strobe256", 256'(strobe256), 256'(1'b0));
    end
    rst = 1'b0;
    @(negedge clk);
    chk("idle_done", 256'(rd64.read_done), 256'(1'b0));
    chk("idle_data", 256'(rd64.read_data), 256'(0));
    chk("idle_pins256", 256'({csb256, load256, pgenb256, strobe256, a256}), 256'(9'b1_0100_0000));

    // sel=1: full pin timing trace and hand-computed data bytes.
    issue(1, 1'b1, n);
    for (int j = 0; j <= 65; j++) begin
      if (j > 0) @(negedge clk);
      chk($sformatf("pins_sel1_j%0d", j), 256'(pins64()), 256'(exp_pins(1, j)));
      if (j == 64) begin
        chk("sel1_byte0", 256'(rd64.read_data[7:0]), 256'(8'h52));
        chk("sel1_byte7", 256'(rd64.read_data[63:56]), 256'(8'h55));
      end
    end

    // Start blocked by an active write.
    @(negedge clk);
    rd64.efuse_busy_write = 1'b1;
    rd64.read_start       = 1'b1;
    rd64.efuse_read_sel   = 2'd2;
    repeat (4) @(negedge clk);
    chk("blocked_busy", 256'(rd64.efuse_busy_read), 256'(1'b0));
    chk("blocked_csb", 256'(csb64), 256'(1'b1));
    rd64.read_start       = 1'b0;
    rd64.efuse_busy_write = 1'b0;

    // Start pulse mid-read must not queue a second read.
    issue(2, 1'b1, n);
    repeat (20) @(negedge clk);
    rd64.read_start     = 1'b1;
    rd64.efuse_read_sel = 2'd0;
    @(negedge clk);
    rd64.read_start = 1'b0;
    repeat (50) @(negedge clk);
    chk("midread_idle", 256'(rd64.efuse_busy_read), 256'(1'b0));
    chk("midread_single_done", 256'(sb_q.size()), 256'(0));

    // Reset in the third strobe cycle of byte 4.
    issue(1, 1'b1, n);
    repeat (36) @(negedge clk);
    chk("pre_reset_strobe", 256'(strobe64), 256'(1'b1));
    sb_q.delete();
    rst = 1'b1;
    @(negedge clk);
    chk("abort_pins", 256'(pins64()), 256'(10'b10_1000_0000));
    chk("abort_data", 256'(rd64.read_data), 256'(0));
    chk("abort_done", 256'(rd64.read_done), 256'(1'b0));
    rst = 1'b0;
    issue(0, 1'b1, n);
    repeat (64) @(negedge clk);
    chk("after_abort_byte0", 256'(rd64.read_data[7:0]), 256'(8'h5A));
    repeat (3) @(negedge clk);

    // sel=3 with start held: back-to-back after one idle cycle.
    rd64.read_start     = 1'b1;
    rd64.efuse_read_sel = 2'd3;
    @(posedge clk);
    #1;
    n = cyc;
    sb_q.push_back('{exp_word(3), n + 64});
    sb_q.push_back('{exp_word(3), n + 130});
    for (int j = 0; j <= 66; j++) begin
      @(negedge clk);
      if (j == 56) chk("sel3_last_addr", 256'(a64), 256'(5'd31));
      if (j == 64) chk("sel3_byte7", 256'(rd64.read_data[63:56]), 256'(8'h45));
      if (j == 65) chk("b2b_idle_gap", 256'(rd64.efuse_busy_read), 256'(1'b0));
      if (j == 66) chk("b2b_reaccept", 256'(rd64.efuse_busy_read), 256'(1'b1));
    end
    rd64.read_start = 1'b0;
    repeat (70) @(negedge clk);
    chk("b2b_idle_end", 256'(rd64.efuse_busy_read), 256'(1'b0));
    chk("b2b_queue_empty", 256'(sb_q.size()), 256'(0));

    // 256-bit instance: single word, addresses 0..31, latency 256.
    @(negedge clk);
    rd256.read_start = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    @(negedge clk);
    rd256.read_start = 1'b0;
    seen   = 1'b0;
    t_done = 0;
    last_a = '0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (i > 0) @(negedge clk);
      if (strobe256) last_a = a256;
      if (rd256.read_done) begin
        seen   = 1'b1;
        t_done = cyc;
      end
    end
    chk("nr256_done_seen", 256'(seen), 256'(1'b1));
    chk("nr256_latency", 256'(t_done - n), 256'(256));
    chk("nr256_last_addr", 256'(last_a), 256'(5'd31));
    chk("nr256_data", rd256.read_data, exp_word256());
    @(negedge clk);
    @(negedge clk);
    chk("nr256_idle", 256'(rd256.efuse_busy_read), 256'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
